// File: rtl/text_pkg.sv
// text_pkg: cell geometry and widths shared by the text glyph renderer.
package text_pkg;
   localparam int CELL_W         = 8;
   localparam int CELL_H         = 8;
   localparam int CHAR_BITS      = 7;
   localparam int GLYPH_ROW_BITS = $clog2(CELL_H);
   localparam int CELL_SHIFT     = $clog2(CELL_W);
endpackage

// File: rtl/cursor_blink_timer.sv
// cursor_blink_timer: counts frame pulses and toggles the blink phase every BLINK_FRAMES pulses.
module cursor_blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   output logic phase
);
   localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (frame_start) begin
         cnt   <= (cnt == CW'(BLINK_FRAMES - 1)) ? '0 : cnt + 1'b1;
         phase <= (cnt == CW'(BLINK_FRAMES - 1)) ? ~phase : phase;
      end
endmodule

// File: rtl/text_glyph_renderer.sv
// text_glyph_renderer: 3-stage text-mode pixel pipeline (cell lookup, font fetch, bit select).
// Optional blinking inverse-video cursor when TEXT_CURSOR_EN is defined.
module text_glyph_renderer
   import text_pkg::*;
#(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int H_BITS       = 10,
   parameter int V_BITS       = 10,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [H_BITS-1:0]             hPos,
   input  logic [V_BITS-1:0]             vPos,
   input  logic                          videoActive,
   input  logic                          frameStart,
   input  logic [6:0]                    cursorX,
   input  logic [4:0]                    cursorY,
   output logic [$clog2(COLS*ROWS)-1:0]  textAddr,
   input  logic [CHAR_BITS-1:0]          textChar,
   output logic [CHAR_BITS-1:0]          charCode,
   output logic [GLYPH_ROW_BITS-1:0]     row,
   input  logic [7:0]                    rowData,
   output logic                          pixelOut,
   output logic                          pixelValid
);
   localparam int AW  = $clog2(COLS * ROWS);
   localparam int CXW = H_BITS - CELL_SHIFT;
   localparam int CYW = V_BITS - CELL_SHIFT;
   logic [CXW-1:0] cell_x;
   logic [CYW-1:0] cell_y;
   logic [AW-1:0] cell_addr;
   logic in_range, in_range1, in_range2, active1, active2, invert;
   logic [GLYPH_ROW_BITS-1:0] glyph_row1;
   logic [CELL_SHIFT-1:0] bit1, bit2;
   assign cell_x    = hPos[H_BITS-1:CELL_SHIFT];
   assign cell_y    = vPos[V_BITS-1:CELL_SHIFT];
   assign in_range  = (cell_x < CXW'(COLS)) && (cell_y < CYW'(ROWS));
   assign cell_addr = AW'(cell_y) * AW'(COLS) + AW'(cell_x);
   assign charCode  = textChar;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         textAddr   <= '0;
         glyph_row1 <= '0;
         bit1       <= '0;
         active1    <= 1'b0;
         in_range1  <= 1'b0;
         row        <= '0;
         bit2       <= '0;
         active2    <= 1'b0;
         in_range2  <= 1'b0;
         pixelOut   <= 1'b0;
         pixelValid <= 1'b0;
      end else begin
         textAddr   <= in_range ? cell_addr : textAddr;
         glyph_row1 <= vPos[GLYPH_ROW_BITS-1:0];
         bit1       <= hPos[CELL_SHIFT-1:0];
         active1    <= videoActive;
         in_range1  <= in_range;
         row        <= glyph_row1;
         bit2       <= bit1;
         active2    <= active1;
         in_range2  <= in_range1;
         // rowData MSB is the leftmost pixel, so pixel column b selects bit 7-b
         pixelOut   <= in_range2 & active2 & (rowData[~bit2] ^ invert);
         pixelValid <= active2;
      end
`ifdef TEXT_CURSOR_EN
   logic hit, hit1, hit2, blink_phase;
   assign hit    = (cell_x == CXW'(cursorX)) && (cell_y == CYW'(cursorY));
   assign invert = blink_phase & hit2;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hit1 <= 1'b0;
         hit2 <= 1'b0;
      end else begin
         hit1 <= hit;
         hit2 <= hit1;
      end
   cursor_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frameStart),
      .phase       (blink_phase)
   );
`else
   localparam int unused_blink = BLINK_FRAMES;
   logic unused_cursor;
   assign unused_cursor = ^{frameStart, cursorX, cursorY};
   assign invert = 1'b0;
`endif
endmodule

// File: tb/tb_text_glyph_renderer.sv
// tb_text_glyph_renderer: scoreboard bench with text RAM and font ROM models.
// Build with TEXT_CURSOR_EN defined to exercise the blinking cursor.
module tb_text_glyph_renderer;
`ifdef TEXT_CURSOR_EN
   localparam int BF = 2;
`else
   localparam int BF = 30;
`endif
   typedef struct {int due; logic pix; logic val;} exp_t;
   logic clk = 1'b0, rst = 1'b0;
   logic [9:0] hPos = '0, vPos = '0;
   logic videoActive = 1'b0, frameStart = 1'b0;
   logic [6:0] cursorX = 7'd1;
   logic [4:0] cursorY = 5'd2;
   logic [11:0] textAddr;
   logic [6:0] textChar = '0, charCode;
   logic [2:0] row;
   logic [7:0] rowData;
   logic pixelOut, pixelValid;
   logic [6:0] mem [0:2399];
   logic [7:0] font [0:1023];
   exp_t q[$];
   int cyc = 0, n_cmp = 0, n_err = 0, fcnt = 0;
   bit phase_m = 1'b0;

   always #5 clk = ~clk;

   text_glyph_renderer #(.BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .hPos(hPos), .vPos(vPos), .videoActive(videoActive),
      .frameStart(frameStart), .cursorX(cursorX), .cursorY(cursorY), .textAddr(textAddr),
      .textChar(textChar), .charCode(charCode), .row(row), .rowData(rowData),
      .pixelOut(pixelOut), .pixelValid(pixelValid)
   );

   always @(posedge clk) textChar <= mem[textAddr];
   assign rowData = font[{charCode, row}];

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         n_cmp += 2;
         if (pixelOut !== e.pix) begin
            n_err++;
            $display("FAIL pixelOut cyc %0d: got %b want %b", cyc, pixelOut, e.pix);
         end
         if (pixelValid !== e.val) begin
            n_err++;
            $display("FAIL pixelValid cyc %0d: got %b want %b", cyc, pixelValid, e.val);
         end
      end
   end

   task automatic put(input int h, input int v, input bit a, input bit fs = 1'b0);
      int cx, cy, b;
      bit inr, inv;
      logic [7:0] f;
      logic [2:0] gr;
      exp_t e;
      hPos = 10'(h); vPos = 10'(v); videoActive = a; frameStart = fs;
`ifdef TEXT_CURSOR_EN
      if (fs) begin
         if (fcnt == BF - 1) begin fcnt = 0; phase_m = ~phase_m; end
         else fcnt++;
      end
`endif
      cx = h / 8; cy = v / 8; b = h % 8; gr = 3'(v % 8);
      inr = (cx < 80) && (cy < 30);
      f = inr ? font[{mem[cy*80+cx], gr}] : 8'h00;
      inv = 1'b0;
`ifdef TEXT_CURSOR_EN
      inv = phase_m && cx == 1 && cy == 2;
`endif
      e.due = cyc + 3; e.pix = a && inr && (f[7-b] ^ inv); e.val = a;
      q.push_back(e);
   endtask

   task automatic drive(input int h, input int v, input bit a, input bit fs = 1'b0);
      @(negedge clk);
      put(h, v, a, fs);
   endtask

   task automatic flush();
      repeat (3) drive(0, 0, 1'b0);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         hPos = 10'($urandom_range(0, 639)); vPos = 10'($urandom_range(0, 239));
         videoActive = 1'b1; frameStart = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if ({textAddr, row, pixelOut, pixelValid} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_hold: got addr %0d row %0d pix %b val %b want all 0", textAddr, row, pixelOut, pixelValid);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      put(0, 0, 1'b1);
      #1 n_cmp++;
      if (pixelValid !== 1'b0) begin n_err++; $display("FAIL release_c0: got %b want 0", pixelValid); end
      for (int i = 1; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (pixelValid !== 1'b0) begin n_err++; $display("FAIL release_c%0d: got %b want 0", i, pixelValid); end
         drive(8 * i, 0, 1'b1);
      end
      flush();
   endtask

   task automatic test_addr();
      drive(9, 17, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (textAddr !== 12'd161) begin n_err++; $display("FAIL textAddr: got %0d want 161", textAddr); end
      drive(9, 17, 1'b1);
      @(posedge clk); #1;
      n_cmp += 2;
      if (row !== 3'd1) begin n_err++; $display("FAIL row: got %0d want 1", row); end
      if (charCode !== 7'h41) begin n_err++; $display("FAIL charCode: got %h want 41", charCode); end
      drive(12, 17, 1'b1);
      drive(15, 17, 1'b1);
      flush();
   endtask

   task automatic test_stream();
      for (int h = 0; h < 8; h++) drive(h, 0, 1'b1);
      flush();
   endtask

   task automatic test_range();
      drive(9, 17, 1'b1);
      drive(640, 17, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (textAddr !== 12'd161) begin n_err++; $display("FAIL addr_hold_h: got %0d want 161", textAddr); end
      drive(0, 240, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (textAddr !== 12'd161) begin n_err++; $display("FAIL addr_hold_v: got %0d want 161", textAddr); end
      drive(645, 17, 1'b0);
      drive(11, 17, 1'b0);
      flush();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 200; i++)
         drive($urandom_range(0, 700), $urandom_range(0, 270), 1'($urandom_range(0, 3) != 0));
      flush();
   endtask

   task automatic test_cursor();
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      drive(8, 16, 1'b1);
      drive(16, 16, 1'b1);
      drive(8, 24, 1'b1);
      flush();
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b1);
      flush();
      drive(8, 16, 1'b1);
      drive(9, 16, 1'b1);
      flush();
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 5; i++) drive(8 * i + 3, 17, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      fcnt = 0; phase_m = 1'b0;
      #1 n_cmp++;
      if ({textAddr, row, pixelOut, pixelValid} !== 17'd0) begin
         n_err++;
         $display("FAIL midreset: got addr %0d row %0d pix %b val %b want all 0", textAddr, row, pixelOut, pixelValid);
      end
      @(negedge clk);
      rst = 1'b0;
      put(9, 17, 1'b1);
      for (int i = 1; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (pixelValid !== 1'b0) begin n_err++; $display("FAIL midrel_c%0d: got %b want 0", i, pixelValid); end
         drive(12 + i, 17, 1'b1);
      end
      flush();
   endtask

   initial begin
      for (int i = 0; i < 2400; i++) mem[i] = 7'($urandom_range(0, 127));
      for (int i = 0; i < 1024; i++) font[i] = 8'($urandom_range(0, 255));
      mem[0] = 7'h05;
      font[{7'h05, 3'd0}] = 8'b1010_0110;
      mem[161] = 7'h41;
      font[{7'h41, 3'd1}] = 8'b0001_1000;
      font[{7'h41, 3'd0}] = 8'b0000_0000;
      test_reset();
      test_addr();
      test_stream();
      test_range();
      test_back_to_back();
      test_cursor();
      test_midreset();
      repeat (5) @(posedge clk);
      #2 n_cmp++;
      if (q.size() != 0) begin n_err++; $display("FAIL drain: got %0d pending want 0", q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
